rs232_tx: RTL
=============

RS232_TX -- requirements
Module: rs232_tx

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200 baud).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port input_tx  input  32  stream word; bits 7:0 are the byte to send, bits 31:8 ignored.
REQ-005 SHALL have port input_tx_stb  input  1  producer asserts while input_tx is valid.
REQ-006 SHALL have port input_tx_ack  output  1  consumer ready; a word transfers on an edge where stb and ack are both high.
REQ-007 SHALL have port tx  output  1  serial line, 8N1, idle high.
REQ-008 SHALL have port busy  output  1  high from the transfer edge until the stop bit completes.

Function
REQ-009 SHALL implement states IDLE, START, DATA, STOP; rst forces IDLE.
REQ-010 In IDLE, SHALL drive input_tx_ack=1, tx=1, busy=0.
REQ-011 On a transfer edge, SHALL latch input_tx[7:0], go to START, and drop input_tx_ack and raise busy from the next cycle.
REQ-012 SHALL not transfer if stb is low at the edge; stb dropping before an edge with ack high is a no-op.
REQ-013 START SHALL drive tx=0 for exactly CLOCKS_PER_BIT cycles, beginning the cycle after the transfer edge.
REQ-014 DATA SHALL shift out 8 bits, LSB first, each held exactly CLOCKS_PER_BIT cycles.
REQ-015 STOP SHALL drive tx=1 for exactly CLOCKS_PER_BIT cycles, then return to IDLE.
REQ-016 Frame SHALL occupy exactly 10*CLOCKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle.
REQ-017 input_tx_ack SHALL be 0 in START, DATA and STOP; no word may be accepted mid-frame.
REQ-018 Back-to-back: with stb held high, the next transfer SHALL occur on the first IDLE edge, giving one idle-high cycle between frames.
REQ-019 Bit timer SHALL be a down-counter of width clog2(CLOCKS_PER_BIT), reloaded to CLOCKS_PER_BIT-1 at each bit boundary; it SHALL never wrap out of range.
REQ-020 Bit index SHALL be a 3-bit counter; DATA ends when index 7 finishes its period.
REQ-021 tx, input_tx_ack and busy SHALL be registered outputs, glitch-free.
REQ-022 CLOCKS_PER_BIT below 2 SHALL be unsupported and flagged by an elaboration-time check.

Reset
REQ-023 Asserting rst SHALL immediately (asynchronously) set state=IDLE, tx=1, input_tx_ack=0, busy=0, and clear counters and the shift register.
REQ-024 input_tx_ack SHALL rise on the first clock edge after rst deasserts.
REQ-025 Reset mid-frame SHALL abort the frame, drive the line high at once, and discard the byte.

Structure
REQ-026 State encoding, bit count (8) and the default CLOCKS_PER_BIT SHALL reside in shared package rs232_pkg, which a future rs232_rx also uses.
REQ-027 Bit-period timing SHALL be a single sub-module rs232_baud_timer (reload input, one-cycle tick output).
REQ-028 Implementation SHALL be synthesizable as a single clock domain with no latches.

Verification (CLOCKS_PER_BIT=4)
REQ-029 Send 0x00000055 -> tx low 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4; ack low for 40 cycles.
REQ-030 Send 0xFFFFFFA3 -> serial byte 0xA3 only (LSB first 1,1,0,0,0,1,0,1); upper bits have no effect.
REQ-031 stb held high with words 0x01 then 0x02 -> two frames separated by exactly one idle-high cycle; both bytes correct.
REQ-032 Assert rst in DATA bit 3 -> tx=1 and busy=0 within the same cycle; after release, ack=1 next edge; new frame of 0x5A is correct.
REQ-033 stb pulsed while busy -> no transfer; word is accepted only once IDLE is reached with stb still high.
REQ-034 Reference model compares each decoded frame with accepted bytes over 1000 random words with random stb gaps -> zero mismatches.

Source files
------------

// File: rtl/rs232_pkg.sv
//------------------------------------------------------------------------------
// Module   : rs232_pkg
// Brief    : Shared RS-232 frame definitions (state encoding, word size,
//            default bit period) for the transmitter and receiver.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rs232_pkg;

    localparam int unsigned c_data_bits              = 8;
    localparam int unsigned c_default_clocks_per_bit = 868;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rs232_state_t;

endpackage

`default_nettype wire

// File: rtl/rs232_baud_timer.sv
//------------------------------------------------------------------------------
// Module   : rs232_baud_timer
// Brief    : Bit-period down-counter; pulses o_tick on the last cycle of
//            each bit period while running.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rs232_baud_timer
    import rs232_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT = c_default_clocks_per_bit
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    input  logic i_reload,
    output logic o_tick
);

    localparam int unsigned         c_cnt_w  = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0]  c_reload = c_cnt_w'(CLOCKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] cnt_q;
    logic [c_cnt_w-1:0] cnt_d;

    // Saturates at zero so the count can never leave 0..CLOCKS_PER_BIT-1.
    always_comb begin
        cnt_d = cnt_q;
        if (i_reload) begin
            cnt_d = c_reload;
        end else if (i_run && (cnt_q != '0)) begin
            cnt_d = cnt_q - c_cnt_w'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = i_run && (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/rs232_tx.sv
//------------------------------------------------------------------------------
// Module   : rs232_tx
// Brief    : 8N1 RS-232 transmitter with a stb/ack stream input.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rs232_tx
    import rs232_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT = c_default_clocks_per_bit
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_tx,
    input  logic        input_tx_stb,
    output logic        input_tx_ack,
    output logic        tx,
    output logic        busy
);

    generate
        if (CLOCKS_PER_BIT < 2) begin : g_cpb_check
            $error("rs232_tx: CLOCKS_PER_BIT must be at least 2");
        end
    endgenerate

    rs232_state_t           state_q;
    rs232_state_t           state_d;
    logic                   tx_q;
    logic                   tx_d;
    logic                   ack_q;
    logic                   ack_d;
    logic                   busy_q;
    logic                   busy_d;
    logic [c_data_bits-1:0] shift_q;
    logic [c_data_bits-1:0] shift_d;
    logic [2:0]             bit_idx_q;
    logic [2:0]             bit_idx_d;

    logic                   w_reload;
    logic                   w_run;
    logic                   w_tick;
    logic                   w_unused_upper;

    assign w_unused_upper = ^input_tx[31:c_data_bits];
    assign w_run          = (state_q != ST_IDLE);

    rs232_baud_timer #(
        .CLOCKS_PER_BIT (CLOCKS_PER_BIT)
    ) u_baud_timer (
        .clk      (clk),
        .rst      (rst),
        .i_run    (w_run),
        .i_reload (w_reload),
        .o_tick   (w_tick)
    );

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        ack_d     = ack_q;
        busy_d    = busy_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        w_reload  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                ack_d  = 1'b1;
                // ack_q gates the transfer so nothing is taken on the first edge out of reset.
                if (ack_q && input_tx_stb) begin
                    state_d   = ST_START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                    ack_d     = 1'b0;
                    shift_d   = input_tx[c_data_bits-1:0];
                    bit_idx_d = 3'd0;
                    w_reload  = 1'b1;
                end
            end

            ST_START: begin
                if (w_tick) begin
                    state_d  = ST_DATA;
                    tx_d     = shift_q[0];
                    shift_d  = {1'b0, shift_q[c_data_bits-1:1]};
                    w_reload = 1'b1;
                end
            end

            ST_DATA: begin
                if (w_tick) begin
                    w_reload = 1'b1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[c_data_bits-1:1]};
                    end
                end
            end

            ST_STOP: begin
                if (w_tick) begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    ack_d   = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                ack_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tx_q      <= 1'b1;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            shift_q   <= '0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    assign tx           = tx_q;
    assign input_tx_ack = ack_q;
    assign busy         = busy_q;

endmodule

`default_nettype wire
